// File: rtl/muldiv_pkg.sv
// Shared types and op-class helpers for the RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed(input muldiv_op_t op);
        return op inside {OP_DIV, OP_REM};
    endfunction

    function automatic logic mul_a_signed(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU};
    endfunction

    function automatic logic mul_b_signed(input muldiv_op_t op);
        return op == OP_MULH;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider on unsigned magnitudes.
// The first quotient bit is resolved in the start cycle; done pulses after XLEN bits.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic            done,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] d;
    logic [CW-1:0]   cnt;
    logic            run;

    logic [XLEN-1:0] r_src;
    logic [XLEN-1:0] q_src;
    logic [XLEN-1:0] d_src;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    assign r_src   = start ? '0 : r;
    assign q_src   = start ? a_mag : q;
    assign d_src   = start ? b_mag : d;
    assign shifted = {r_src, q_src[XLEN-1]};
    assign diff    = shifted - {1'b0, d_src};

    always_ff @(posedge clk) begin
        if (rst) begin
            run  <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            q    <= '0;
            r    <= '0;
            d    <= '0;
        end else begin
            done <= 1'b0;
            if (start || run) begin
                r <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                q <= {q_src[XLEN-2:0], ~diff[XLEN]};
                d <= d_src;
            end
            if (start) begin
                cnt <= CW'(1);
                run <= 1'b1;
            end else if (run) begin
                cnt <= cnt + CW'(1);
                if (cnt == CW'(XLEN - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: valid/ready in, valid/ready out, one op in flight.
// Define MULDIV_EARLY_OUT_EN to short-circuit divides whose |a| < |b|.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input  logic             ACLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    import muldiv_pkg::*;

    localparam int PW = 2 * XLEN + 2;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t state;
    muldiv_op_t    op_in;
    muldiv_op_t    op_q;
    muldiv_op_t    mul_op;
    logic          neg_q;
    logic          neg_r;
    logic [1:0]    mul_cnt;

    assign op_in = muldiv_op_t'(in_op);

    // Multiplier: product of the incoming operands, retimed by MUL_STAGES-1 regs.
    logic signed [XLEN:0] sa;
    logic signed [XLEN:0] sb;
    logic signed [PW-1:0] prod_in;
    logic [PW-1:0]        tap;
    logic [XLEN-1:0]      mul_res;
    logic                 unused_tap;

    assign sa      = {mul_a_signed(op_in) & in_a[XLEN-1], in_a};
    assign sb      = {mul_b_signed(op_in) & in_b[XLEN-1], in_b};
    assign prod_in = PW'(sa) * PW'(sb);

    if (MUL_STAGES == 1) begin : g_mul1
        assign tap = prod_in;
    end else begin : g_mulp
        logic [PW-1:0] pipe [MUL_STAGES-1];
        always_ff @(posedge ACLK) begin
            pipe[0] <= prod_in;
            for (int i = 1; i < MUL_STAGES - 1; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
        assign tap = pipe[MUL_STAGES-2];
    end

    assign mul_op     = (MUL_STAGES == 1) ? op_in : op_q;
    assign mul_res    = (mul_op == OP_MUL) ? tap[XLEN-1:0]
                                           : tap[2*XLEN-1:XLEN];
    assign unused_tap = ^tap[PW-1:2*XLEN];

    // Divide operand conditioning and fast paths.
    logic            a_neg_in;
    logic            b_neg_in;
    logic [XLEN-1:0] a_mag_in;
    logic [XLEN-1:0] b_mag_in;
    logic            div_zero;
    logic            div_ovf;
    logic            early;
    logic            fast;
    logic [XLEN-1:0] fast_res;
    logic            div_start;

    assign a_neg_in = is_signed(op_in) & in_a[XLEN-1];
    assign b_neg_in = is_signed(op_in) & in_b[XLEN-1];
    assign a_mag_in = a_neg_in ? -in_a : in_a;
    assign b_mag_in = b_neg_in ? -in_b : in_b;
    assign div_zero = (in_b == '0);
    assign div_ovf  = is_signed(op_in) && (in_a == INT_MIN) && (&in_b);

`ifdef MULDIV_EARLY_OUT_EN
    assign early = (a_mag_in < b_mag_in);
`else
    assign early = 1'b0;
`endif

    assign fast = div_zero | div_ovf | early;

    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = is_rem(op_in) ? in_a : '1;
        end else if (div_ovf) begin
            fast_res = is_rem(op_in) ? '0 : in_a;
        end else if (early) begin
            fast_res = is_rem(op_in) ? in_a : '0;
        end
    end

    assign div_start = in_valid && in_ready && is_div(op_in) && !fast;

    logic            div_done;
    logic [XLEN-1:0] div_q;
    logic [XLEN-1:0] div_r;
    logic [XLEN-1:0] div_res;

    div_iter #(
        .XLEN (XLEN)
    ) u_div_iter (
        .clk   (ACLK),
        .rst   (RESET),
        .start (div_start),
        .a_mag (a_mag_in),
        .b_mag (b_mag_in),
        .done  (div_done),
        .q     (div_q),
        .r     (div_r)
    );

    // Quotient negated on sign mismatch; remainder follows the dividend.
    assign div_res = is_rem(op_q) ? (neg_r ? -div_r : div_r)
                                  : (neg_q ? -div_q : div_q);

    always_ff @(posedge ACLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            op_q       <= OP_MUL;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            mul_cnt    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q     <= op_in;
                        out_tag  <= in_tag;
                        neg_q    <= a_neg_in ^ b_neg_in;
                        neg_r    <= a_neg_in;
                        mul_cnt  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (!is_div(op_in)) begin
                            if (MUL_STAGES == 1) begin
                                state      <= ST_DONE;
                                out_valid  <= 1'b1;
                                out_result <= mul_res;
                            end else begin
                                state <= ST_MUL;
                            end
                        end else if (fast) begin
                            state      <= ST_DONE;
                            out_valid  <= 1'b1;
                            out_result <= fast_res;
                        end else begin
                            state <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_cnt == 2'(MUL_STAGES - 2)) begin
                        state      <= ST_DONE;
                        out_valid  <= 1'b1;
                        out_result <= mul_res;
                    end else begin
                        mul_cnt <= mul_cnt + 2'd1;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state      <= ST_DONE;
                        out_valid  <= 1'b1;
                        out_result <= div_res;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
